// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a data/go/bsy handshake.
// Holds data stable per frame and drops go between frames, retrying on a go timeout.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GO_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            uart_data,
  output logic                  uart_go,
  input  logic                  uart_bsy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMO_W = (GO_TIMEOUT > 1) ? $clog2(GO_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(GO_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_BUSY, S_RELEASE} state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q, overflow_q;
  state_t                state_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [7:0]            uart_data_q;
  logic                  uart_go_q;
  logic                  push, pop;

  // Drops use the registered full flag, so a pop on the same edge cannot rescue a write.
  assign push = wr_en && !full_q;
  assign pop  = (state_q == S_BUSY) && !uart_bsy;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_en && full_q)
        overflow_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // The head is only read here; the pop waits until the transmitter finishes the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      uart_data_q <= 8'h00;
      uart_go_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty_q && !uart_bsy) begin
            uart_data_q <= mem_q[rd_ptr_q];
            uart_go_q   <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_GO;
          end
        end
        S_GO: begin
          if (uart_bsy) begin
            state_q <= S_BUSY;
          end else if (tmo_q == TMO_LAST) begin
            uart_go_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_BUSY: begin
          if (!uart_bsy) begin
            uart_go_q <= 1'b0;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign uart_data = uart_data_q;
  assign uart_go   = uart_go_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter and a byte scoreboard.
// Accepted writes queue their byte; a monitor pops and compares whenever a frame starts.
module tb_uart_tx_fifo;
  localparam int DL2   = 2;
  localparam int GTO   = 4;
  localparam int FRAME = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     wr_data = 8'h00;
  logic           wr_en = 1'b0;
  logic           full, empty, overflow, uart_go, uart_bsy;
  logic [DL2:0]   count;
  logic [7:0]     uart_data;
  logic           tx_bsy = 1'b0;
  logic           hold = 1'b0;

  assign uart_bsy = tx_bsy | hold;

  uart_tx_fifo #(.DEPTH_LOG2(DL2), .GO_TIMEOUT(GTO)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .uart_data(uart_data), .uart_go(uart_go), .uart_bsy(uart_bsy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: raises bsy on the falling edge after go, sends FRAME cycles,
  // then waits for an observed falling edge of go before accepting another request.
  typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_PARK} tx_t;
  tx_t  tx_st = TX_IDLE;
  int   tx_cnt = 0;
  logic go_prev_n = 1'b0;

  always @(negedge clk) begin
    go_prev_n <= uart_go;
    case (tx_st)
      TX_IDLE: if (uart_go && !hold) begin
        tx_bsy <= 1'b1;
        tx_cnt <= FRAME - 1;
        tx_st  <= TX_FRAME;
      end
      TX_FRAME: begin
        if (tx_cnt == 0) begin
          tx_bsy <= 1'b0;
          tx_st  <= TX_PARK;
        end else begin
          tx_cnt <= tx_cnt - 1;
        end
      end
      TX_PARK: if (go_prev_n && !uart_go) tx_st <= TX_IDLE;
      default: tx_st <= TX_IDLE;
    endcase
  end

  int         frames = 0;
  logic [7:0] mon_byte = 8'h00;
  bit         chk_stable = 1'b1;

  initial forever begin
    @(posedge tx_bsy);
    frames++;
    mon_byte = uart_data;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_byte: got %0h expected no frame", uart_data);
    end else begin
      chk("frame_byte", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
    end
  end

  initial forever begin
    @(negedge tx_bsy);
    if (chk_stable) chk("data_stable", {24'h0, uart_data}, {24'h0, mon_byte});
  end

  // Edge-level monitor for go pulses, go timeouts and the bsy-low to go-high gap.
  int go_rises = 0, tmo_events = 0, last_tmo = 0, hi_len = 0, gap_cnt = 0;
  bit saw_bsy = 0, gap_active = 0, check_gap = 0;
  logic go_p = 1'b0, bsy_p = 1'b0;

  initial forever begin
    @(posedge clk); #1;
    if (gap_active) gap_cnt++;
    if (uart_go && !go_p) begin
      go_rises++;
      if (gap_active && check_gap) chk("gap_edges", gap_cnt, 3);
      gap_active = 0;
      hi_len = 0;
      saw_bsy = 0;
    end
    if (uart_go) begin
      hi_len++;
      if (uart_bsy) saw_bsy = 1;
    end
    if (!uart_go && go_p && !saw_bsy) begin
      tmo_events++;
      last_tmo = hi_len;
    end
    if (!uart_bsy && bsy_p) begin
      gap_active = 1;
      gap_cnt = 1;
    end
    go_p  = uart_go;
    bsy_p = uart_bsy;
  end

  task automatic wr(input logic [7:0] b, input bit acc);
    @(negedge clk); #1;
    wr_data = b;
    wr_en = 1'b1;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic stop_wr();
    @(negedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic post();
    @(posedge clk); #1;
  endtask

  task automatic wait_bsy(input logic lvl, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (uart_bsy !== lvl && n < 500);
    if (uart_bsy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: bsy still %0b after %0d cycles, expected %0b", name, uart_bsy, n, lvl);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(empty && !uart_go && !uart_bsy && tx_st == TX_IDLE) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout, count %0d expected 0", name, count);
    end
  endtask

  int r0, t0, f0;

  initial begin
    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_go", uart_go, 0);
    chk("rst_data", uart_data, 8'h00);
    @(negedge clk); #1;
    rst = 1'b0;

    // Single byte: go one edge after the write edge
    wr(8'hA5, 1);
    post();
    chk("single_empty", empty, 0);
    chk("single_count", count, 1);
    chk("single_go_early", uart_go, 0);
    stop_wr();
    post();
    chk("single_go", uart_go, 1);
    chk("single_data", uart_data, 8'hA5);
    wait_idle("single");
    chk("single_end_empty", empty, 1);
    chk("single_end_go", uart_go, 0);

    // Burst of three, count peaks at 3, gaps of 3 edges
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    post();
    chk("burst_count", count, 3);
    stop_wr();
    check_gap = 1;
    wait_idle("burst");
    check_gap = 0;

    // Fill and overflow with the transmitter held busy
    @(negedge clk); #1;
    hold = 1'b1;
    wr(8'hA0, 1);
    wr(8'hA1, 1);
    wr(8'hA2, 1);
    wr(8'hA3, 1);
    post();
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf_clear", overflow, 0);
    wr(8'hA4, 0);
    post();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    stop_wr();
    hold = 1'b0;

    // Write on the pop edge is dropped; the next one is accepted
    wait_bsy(1'b1, "popwr_rise");
    wait_bsy(1'b0, "popwr_fall");
    wr_data = 8'hF0;
    wr_en = 1'b1;
    post();
    chk("popwr_count", count, 3);
    chk("popwr_full", full, 0);
    wr(8'hF1, 1);
    post();
    chk("popwr_next_count", count, 4);
    chk("popwr_next_full", full, 1);
    stop_wr();
    wait_idle("popwr");
    chk("ovf_sticky", overflow, 1);
    chk("popwr_empty", empty, 1);
    chk("popwr_drained", count, 0);

    // Write during RELEASE
    wr(8'h11, 1);
    wr(8'h22, 1);
    stop_wr();
    wait_bsy(1'b1, "rel_rise");
    wait_bsy(1'b0, "rel_fall");
    chk("rel_count_pre", count, 2);
    post();
    chk("rel_count_pop", count, 1);
    wr(8'h33, 1);
    post();
    chk("rel_count_wr", count, 2);
    stop_wr();
    wait_idle("release");

    // Block reset mid-frame, then a byte that needs one go retry
    wr(8'h3C, 1);
    stop_wr();
    wait_bsy(1'b1, "rst_rise");
    repeat (10) @(negedge clk);
    #1;
    chk_stable = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_go", uart_go, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_data", uart_data, 8'h00);
    @(negedge clk); #1;
    rst = 1'b0;
    r0 = go_rises;
    t0 = tmo_events;
    f0 = frames;
    wr(8'h7E, 1);
    stop_wr();
    wait_idle("retry");
    chk_stable = 1'b1;
    chk("retry_go_pulses", go_rises - r0, 2);
    chk("retry_timeouts", tmo_events - t0, 1);
    chk("retry_tmo_len", last_tmo, GTO);
    chk("retry_frames", frames - f0, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
